// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and FSM state type for the instruction cache responder
// Contents:
//   IDX_BITS_DEF  default number of line-index bits
//   LINE_W        instruction packet / line width in bits
//   PADDR_W       physical packet address width (16-byte granule)
//   state_t       responder FSM state encoding
package icache_pkg;

  localparam int IDX_BITS_DEF = 6;
  localparam int LINE_W       = 128;
  localparam int PADDR_W      = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MISS   = 2'd2
  } state_t;

endpackage

// File: rtl/icache_ram.sv
// rtl/icache_ram.sv - tag+data line storage, one synchronous read port and one write port
// Ports:
//   clk      in   clock, read and write on rising edge
//   rd_en    in   capture mem[rd_addr] into rd_data on this edge
//   rd_addr  in   ADDR_W read index
//   rd_data  out  DATA_W registered read data (holds when rd_en=0)
//   wr_en    in   write wr_data to mem[wr_addr] on this edge
//   wr_addr  in   ADDR_W write index
//   wr_data  in   DATA_W write data
// Contents are not reset; the owner keeps per-line valid state separately.
module icache_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 150
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache front end with single-beat line fill
// Optional feature macro: ICACHE_PERF_EN (adds ic_hit_cnt / ic_miss_cnt ports and counters)
// Ports:
//   clkrst_core_clk  in   core clock, all state on rising edge
//   clkrst_core_rst  in   synchronous active-high reset
//   f2ic_valid       in   fetch request valid, held until ic2f_ready
//   f2ic_paddr       in   28-bit physical packet address
//   ic2f_ready       out  packet valid this cycle, request complete
//   ic2f_packet      out  128-bit instruction packet, zero when ic2f_ready=0
//   pipe_flush       in   abandon an in-flight lookup (fills still complete)
//   ic_inval         in   invalidate-all pulse
//   ic2mem_req       out  line fill request, held until mem2ic_valid
//   ic2mem_addr      out  28-bit fill address, zero when no request
//   mem2ic_valid     in   fill data valid, single beat
//   mem2ic_data      in   128-bit fill data
//   ic_hit_cnt       out  32-bit wrapping hit count (ICACHE_PERF_EN)
//   ic_miss_cnt      out  32-bit wrapping miss count (ICACHE_PERF_EN)
module icache_responder
  import icache_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst,
  input  logic                f2ic_valid,
  input  logic [PADDR_W-1:0]  f2ic_paddr,
  output logic                ic2f_ready,
  output logic [LINE_W-1:0]   ic2f_packet,
  input  logic                pipe_flush,
  input  logic                ic_inval,
  output logic                ic2mem_req,
  output logic [PADDR_W-1:0]  ic2mem_addr,
  input  logic                mem2ic_valid,
  input  logic [LINE_W-1:0]   mem2ic_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]         ic_hit_cnt,
  output logic [31:0]         ic_miss_cnt
`endif
);

  localparam int TAG_W  = PADDR_W - IDX_BITS;
  localparam int NLINES = 1 << IDX_BITS;
  localparam int ENTRY_W = TAG_W + LINE_W;

  state_t               state_q, state_d;
  logic [PADDR_W-1:0]   lkp_addr_q, lkp_addr_d;
  logic [NLINES-1:0]    valid_q, valid_d;
  logic                 inval_pend_q, inval_pend_d;

  logic                 rd_en;
  logic                 wr_en;
  logic [ENTRY_W-1:0]   rd_entry;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_W-1:0]    rd_line;

  logic [IDX_BITS-1:0]  lkp_idx;
  logic [TAG_W-1:0]     lkp_tag;
  logic                 same_req;
  logic                 line_hit;

  assign lkp_idx = lkp_addr_q[IDX_BITS-1:0];
  assign lkp_tag = lkp_addr_q[PADDR_W-1:IDX_BITS];
  assign rd_tag  = rd_entry[ENTRY_W-1:LINE_W];
  assign rd_line = rd_entry[LINE_W-1:0];

  // The array read was launched from IDLE with the address now held in
  // lkp_addr; the fetch unit must still be asking for that same packet.
  assign same_req = f2ic_valid && (f2ic_paddr == lkp_addr_q);
  assign line_hit = valid_q[lkp_idx] && (rd_tag == lkp_tag);

  icache_ram #(
    .ADDR_W (IDX_BITS),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk     (clkrst_core_clk),
    .rd_en   (rd_en),
    .rd_addr (f2ic_paddr[IDX_BITS-1:0]),
    .rd_data (rd_entry),
    .wr_en   (wr_en),
    .wr_addr (lkp_idx),
    .wr_data ({lkp_tag, mem2ic_data})
  );

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q      <= ST_IDLE;
      lkp_addr_q   <= '0;
      valid_q      <= '0;
      inval_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lkp_addr_q   <= lkp_addr_d;
      valid_q      <= valid_d;
      inval_pend_q <= inval_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lkp_addr_d   = lkp_addr_q;
    valid_d      = valid_q;
    inval_pend_d = inval_pend_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    ic2f_ready   = 1'b0;
    ic2f_packet  = '0;
    ic2mem_req   = 1'b0;
    ic2mem_addr  = '0;

    case (state_q)
      ST_IDLE: begin
        // A deferred invalidate from a fill is applied here, one cycle
        // after the fill write, and takes the cycle instead of a launch.
        if (ic_inval || inval_pend_q) begin
          valid_d      = '0;
          inval_pend_d = 1'b0;
        end else if (f2ic_valid) begin
          rd_en      = 1'b1;
          lkp_addr_d = f2ic_paddr;
          state_d    = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (ic_inval) begin
          valid_d = '0;
          state_d = ST_IDLE;
        end else if (pipe_flush || !same_req) begin
          state_d = ST_IDLE;
        end else if (line_hit) begin
          ic2f_ready  = 1'b1;
          ic2f_packet = rd_line;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_MISS;
        end
      end

      ST_MISS: begin
        // Flush does not abort a fill; invalidates are remembered and
        // applied after the line is written so the fill is also cleared.
        ic2mem_req  = 1'b1;
        ic2mem_addr = lkp_addr_q;
        if (ic_inval) begin
          inval_pend_d = 1'b1;
        end
        if (mem2ic_valid) begin
          wr_en            = 1'b1;
          valid_d[lkp_idx] = 1'b1;
          state_d          = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic miss_evt;

  assign miss_evt = (state_q == ST_LOOKUP) && (state_d == ST_MISS);

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      ic_hit_cnt  <= '0;
      ic_miss_cnt <= '0;
    end else begin
      if (ic2f_ready) begin
        ic_hit_cnt <= ic_hit_cnt + 32'd1;
      end
      if (miss_evt) begin
        ic_miss_cnt <= ic_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - self-checking bench for icache_responder with a line-array reference model
module tb_icache_responder;

  localparam int IDX  = 6;
  localparam int NL   = 1 << IDX;
  localparam int TAGW = 28 - IDX;

  logic          clk;
  logic          rst;
  logic          f2ic_valid;
  logic [27:0]   f2ic_paddr;
  logic          ic2f_ready;
  logic [127:0]  ic2f_packet;
  logic          pipe_flush;
  logic          ic_inval;
  logic          ic2mem_req;
  logic [27:0]   ic2mem_addr;
  logic          mem2ic_valid;
  logic [127:0]  mem2ic_data;
`ifdef ICACHE_PERF_EN
  logic [31:0]   ic_hit_cnt;
  logic [31:0]   ic_miss_cnt;
`endif

  icache_responder #(.IDX_BITS(IDX)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .f2ic_valid      (f2ic_valid),
    .f2ic_paddr      (f2ic_paddr),
    .ic2f_ready      (ic2f_ready),
    .ic2f_packet     (ic2f_packet),
    .pipe_flush      (pipe_flush),
    .ic_inval        (ic_inval),
    .ic2mem_req      (ic2mem_req),
    .ic2mem_addr     (ic2mem_addr),
    .mem2ic_valid    (mem2ic_valid),
    .mem2ic_data     (mem2ic_data)
`ifdef ICACHE_PERF_EN
    ,
    .ic_hit_cnt      (ic_hit_cnt),
    .ic_miss_cnt     (ic_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what each cache line should hold.
  bit            m_valid [NL];
  logic [TAGW-1:0] m_tag [NL];
  logic [127:0]  m_data  [NL];
  logic [31:0]   m_hits;
  logic [31:0]   m_miss;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [27:0] a, input logic [127:0] d);
    int ix;
    ix = int'(a % NL);
    m_valid[ix] = 1'b1;
    m_tag[ix]   = a / NL;
    m_data[ix]  = d;
  endtask

  function automatic bit model_hit(input logic [27:0] a);
    int ix;
    ix = int'(a % NL);
    return m_valid[ix] && (m_tag[ix] == TAGW'(a / NL));
  endfunction

  // Full fetch transaction: present a, serve any fill, wait for the packet.
  task automatic do_fetch(input logic [27:0] a, input bit fixed, input logic [127:0] fv, input string nm);
    bit exp_hit, got, saw_req, bad_addr, bad_pkt;
    int cyc, first_ready;
    logic [127:0] exp_data, got_data, fill;
    exp_hit = model_hit(a);
    exp_data = m_data[int'(a % NL)];
    got = 0; saw_req = 0; bad_addr = 0; bad_pkt = 0; cyc = 0; first_ready = 0;
    got_data = '0;
    f2ic_valid = 1'b1;
    f2ic_paddr = a;
    while (!got && cyc < 40) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (ic2f_ready) begin
        got = 1; got_data = ic2f_packet; first_ready = cyc;
      end else begin
        if (ic2f_packet !== '0) bad_pkt = 1;
        if (ic2mem_req) begin
          saw_req = 1;
          if (ic2mem_addr !== a) bad_addr = 1;
          fill = fixed ? fv : rand128();
          mem2ic_valid = 1'b1;
          mem2ic_data  = fill;
          @(posedge clk); #1;
          mem2ic_valid = 1'b0;
          mem2ic_data  = '0;
          model_fill(a, fill);
          exp_data = fill;
        end
      end
    end
    @(posedge clk); #1;
    f2ic_valid = 1'b0;
    if (!exp_hit) m_miss = m_miss + 32'd1;
    if (got) m_hits = m_hits + 32'd1;

    checks++;
    if (!got) begin
      errors++; $display("FAIL %s timeout: ready=0 after %0d cycles, required ready=1", nm, cyc);
    end
    checks++;
    if (got_data !== exp_data) begin
      errors++; $display("FAIL %s data: got %h required %h", nm, got_data, exp_data);
    end
    checks++;
    if (exp_hit && (saw_req || first_ready != 1)) begin
      errors++; $display("FAIL %s hit: req=%0b latency=%0d, required req=0 latency=1", nm, saw_req, first_ready);
    end else if (!exp_hit && !saw_req) begin
      errors++; $display("FAIL %s miss: ic2mem_req=0, required 1", nm);
    end
    checks++;
    if (bad_addr) begin
      errors++; $display("FAIL %s fill_addr: ic2mem_addr differed, required %h", nm, a);
    end
    checks++;
    if (bad_pkt) begin
      errors++; $display("FAIL %s pkt_zero: nonzero packet without ready, required 0", nm);
    end
  endtask

  task automatic wait_req(input logic [27:0] a, input string nm);
    f2ic_valid = 1'b1;
    f2ic_paddr = a;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (ic2mem_req !== 1'b1 || ic2mem_addr !== a) begin
      errors++; $display("FAIL %s req: req=%0b addr=%h, required 1 %h", nm, ic2mem_req, ic2mem_addr, a);
    end
  endtask

  task automatic check_counters(input string nm);
`ifdef ICACHE_PERF_EN
    checks++;
    if (ic_hit_cnt !== m_hits || ic_miss_cnt !== m_miss) begin
      errors++; $display("FAIL %s counters: hit=%0d miss=%0d required %0d %0d", nm, ic_hit_cnt, ic_miss_cnt, m_hits, m_miss);
    end
`endif
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear(); m_hits = 0; m_miss = 0;
    @(negedge clk);
    checks++;
    if (ic2f_ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %0b required 0", ic2f_ready); end
    checks++;
    if (ic2f_packet !== '0) begin errors++; $display("FAIL reset packet: got %h required 0", ic2f_packet); end
    checks++;
    if (ic2mem_req !== 1'b0) begin errors++; $display("FAIL reset req: got %0b required 0", ic2mem_req); end
    checks++;
    if (ic2mem_addr !== '0) begin errors++; $display("FAIL reset addr: got %h required 0", ic2mem_addr); end
    check_counters("reset");
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ic2f_ready !== 1'b0 || ic2mem_req !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_quiet: ready/req asserted with no request, required 0"); end
  endtask

  task automatic test_cold_miss();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    do_fetch(28'h0000040, 1'b1, a5, "cold_miss");
    check_counters("cold_miss");
  endtask

  task automatic test_repeat_hit();
    do_fetch(28'h0000040, 1'b0, '0, "repeat_hit");
  endtask

  task automatic test_conflict();
    do_fetch(28'h0000080, 1'b0, '0, "conflict_b");
    do_fetch(28'h0000040, 1'b0, '0, "conflict_a");
    do_fetch(28'h0000040, 1'b0, '0, "conflict_a_hit");
  endtask

  task automatic test_flush_mid_miss();
    logic [127:0] fill;
    wait_req(28'h0000100, "flush");
    pipe_flush = 1'b1;
    f2ic_paddr = 28'h0000007;
    @(posedge clk); @(negedge clk);
    pipe_flush = 1'b0;
    checks++;
    if (ic2mem_req !== 1'b1 || ic2mem_addr !== 28'h0000100 || ic2f_ready !== 1'b0) begin
      errors++; $display("FAIL flush hold: req=%0b addr=%h ready=%0b, required 1 0000100 0", ic2mem_req, ic2mem_addr, ic2f_ready);
    end
    fill = rand128();
    mem2ic_valid = 1'b1;
    mem2ic_data = fill;
    @(posedge clk); #1;
    mem2ic_valid = 1'b0;
    mem2ic_data = '0;
    model_fill(28'h0000100, fill);
    m_miss = m_miss + 32'd1;
    do_fetch(28'h0000007, 1'b0, '0, "flush_new");
    do_fetch(28'h0000100, 1'b0, '0, "flush_old_hit");
  endtask

  task automatic test_inval_during_miss();
    logic [127:0] fill;
    wait_req(28'h00000C5, "inval_miss");
    ic_inval = 1'b1;
    @(posedge clk); @(negedge clk);
    ic_inval = 1'b0;
    checks++;
    if (ic2mem_req !== 1'b1) begin errors++; $display("FAIL inval_miss hold: req=%0b required 1", ic2mem_req); end
    fill = rand128();
    f2ic_valid = 1'b0;
    mem2ic_valid = 1'b1;
    mem2ic_data = fill;
    @(posedge clk); #1;
    mem2ic_valid = 1'b0;
    mem2ic_data = '0;
    m_miss = m_miss + 32'd1;
    model_clear();
    do_fetch(28'h00000C5, 1'b0, '0, "inval_refetch");
    do_fetch(28'h0000100, 1'b0, '0, "inval_other");
  endtask

  task automatic test_inval_vs_hit();
    do_fetch(28'h000002A, 1'b0, '0, "ivh_prime");
    f2ic_valid = 1'b1;
    f2ic_paddr = 28'h000002A;
    @(posedge clk); #1;
    ic_inval = 1'b1;
    @(negedge clk);
    checks++;
    if (ic2f_ready !== 1'b0 || ic2f_packet !== '0) begin
      errors++; $display("FAIL inval_vs_hit: ready=%0b packet=%h required 0 0", ic2f_ready, ic2f_packet);
    end
    @(posedge clk); #1;
    ic_inval = 1'b0;
    f2ic_valid = 1'b0;
    model_clear();
    do_fetch(28'h000002A, 1'b0, '0, "ivh_refetch");
  endtask

  task automatic test_reset_mid_miss();
    bit bad;
    wait_req(28'h0000333, "rst_miss");
    rst = 1'b1;
    f2ic_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(); m_hits = 0; m_miss = 0;
    @(negedge clk);
    checks++;
    if (ic2mem_req !== 1'b0 || ic2mem_addr !== '0) begin
      errors++; $display("FAIL rst_miss drop: req=%0b addr=%h required 0 0", ic2mem_req, ic2mem_addr);
    end
    mem2ic_valid = 1'b1;
    mem2ic_data = rand128();
    @(posedge clk); #1;
    mem2ic_valid = 1'b0;
    mem2ic_data = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ic2f_ready !== 1'b0 || ic2mem_req !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_miss late_fill: ready/req asserted, required 0"); end
    check_counters("rst_miss");
    do_fetch(28'h0000333, 1'b0, '0, "rst_refetch");
  endtask

  task automatic test_random();
    logic [27:0] a;
    for (int n = 0; n < 40; n++) begin
      a = (28'($urandom_range(0, 2)) << IDX) | 28'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        ic_inval = 1'b1;
        @(posedge clk); #1;
        ic_inval = 1'b0;
        model_clear();
      end
      do_fetch(a, 1'b0, '0, "random");
    end
    check_counters("random");
  endtask

  initial begin
    rst = 1'b1;
    f2ic_valid = 1'b0;
    f2ic_paddr = '0;
    pipe_flush = 1'b0;
    ic_inval = 1'b0;
    mem2ic_valid = 1'b0;
    mem2ic_data = '0;
    m_hits = 0;
    m_miss = 0;
    model_clear();
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_conflict();
    test_flush_mid_miss();
    test_inval_during_miss();
    test_inval_vs_hit();
    test_reset_mid_miss();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
